// File: rtl/drp_pkg.sv
// drp_pkg: shared state encoding, register addresses and default ID for the DRP responder.
package drp_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} drp_state_t;
  localparam int DRP_ADDR_ID = 0;
  localparam int DRP_ADDR_CTRL = 1;
  localparam int DRP_ADDR_STATUS = 2;
  localparam logic [15:0] DRP_ID_VALUE = 16'hD2B0;
endpackage

// File: rtl/drp_regfile.sv
// drp_regfile: register array with write port and combinational read mux (ID, STATUS, out-of-range decode).
module drp_regfile
  import drp_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 16,
  parameter int DEPTH = 16,
  parameter logic [DATA_W-1:0] ID_VALUE = DATA_W'(DRP_ID_VALUE)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  input  logic [DATA_W-1:0] status_in,
  output logic [DATA_W-1:0] rdata,
  output logic [DATA_W-1:0] ctrl
);
  localparam int IW = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] LIM = ADDR_W'(DEPTH);
  logic [DATA_W-1:0] regs [DEPTH];
  logic writable;
  assign writable = we && waddr < LIM && waddr != ADDR_W'(DRP_ADDR_ID)
                    && waddr != ADDR_W'(DRP_ADDR_STATUS);
  always_ff @(posedge clk or posedge rst)
    if (rst) for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    else if (writable) regs[waddr[IW-1:0]] <= wdata;
  // full-width compare so addresses beyond DEPTH never alias onto scratch
  always_comb
    rdata = raddr >= LIM ? '0 :
            raddr == ADDR_W'(DRP_ADDR_ID) ? ID_VALUE :
            raddr == ADDR_W'(DRP_ADDR_STATUS) ? status_in :
            regs[raddr[IW-1:0]];
  assign ctrl = regs[DRP_ADDR_CTRL];
endmodule

// File: rtl/drp_responder.sv
// drp_responder: DRP slave with fixed response latency, CTRL/STATUS/scratch registers and sticky error flags.
module drp_responder
  import drp_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 16,
  parameter int DEPTH = 16,
  parameter int LATENCY = 3,
  parameter logic [DATA_W-1:0] ID_VALUE = DATA_W'(DRP_ID_VALUE)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              den,
  input  logic              dwe,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [DATA_W-1:0] di,
  output logic              drdy,
  output logic [DATA_W-1:0] do_o,
  output logic [DATA_W-1:0] ctrl_out,
  input  logic [DATA_W-1:0] status_in,
  output logic              busy_err,
  output logic              addr_err
);
  localparam int CW = $clog2(LATENCY + 1);
  drp_state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic dwe_q, accept, busy;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] rdata;
  // the drdy cycle itself is still busy: a den there is dropped
  assign accept = den && state == IDLE && !drdy;
  assign busy = den && !accept;
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    case (state)
      IDLE: if (accept) begin
        state_n = LATENCY == 1 ? RESP : WAIT;
        cnt_n = CW'(1);
      end
      WAIT: begin
        cnt_n = cnt + 1'b1;
        if (cnt == CW'(LATENCY - 1)) state_n = RESP;
      end
      default: begin
        state_n = IDLE;
        cnt_n = '0;
      end
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      dwe_q <= 1'b0;
      addr_q <= '0;
      drdy <= 1'b0;
      do_o <= '0;
      busy_err <= 1'b0;
      addr_err <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      if (accept) begin
        dwe_q <= dwe;
        addr_q <= daddr;
      end
      drdy <= state == RESP;
      do_o <= state == RESP && !dwe_q ? rdata : '0;
      busy_err <= busy_err | busy;
      addr_err <= addr_err | (accept && daddr >= ADDR_W'(DEPTH));
    end
  drp_regfile #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .ID_VALUE(ID_VALUE)) u_regs (
    .clk(clk),
    .rst(rst),
    .we(accept && dwe),
    .waddr(daddr),
    .wdata(di),
    .raddr(addr_q),
    .status_in(status_in),
    .rdata(rdata),
    .ctrl(ctrl_out)
  );
endmodule

// File: tb/tb_drp_responder.sv
// tb_drp_responder: directed DRP transactions checked with immediate assertions at LATENCY=3, DEPTH=16.
module tb_drp_responder;
  logic clk = 1'b0, rst = 1'b1, den = 1'b0, dwe = 1'b0;
  logic [9:0] daddr = '0;
  logic [15:0] di = '0, status_in = '0, do_o, ctrl_out;
  logic drdy, busy_err, addr_err;
  int n_cmp = 0, n_err = 0;
  drp_responder dut (
    .clk(clk), .rst(rst), .den(den), .dwe(dwe), .daddr(daddr), .di(di),
    .drdy(drdy), .do_o(do_o), .ctrl_out(ctrl_out), .status_in(status_in),
    .busy_err(busy_err), .addr_err(addr_err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic txn(input logic we, input logic [9:0] a, input logic [15:0] d, input logic [15:0] exp);
    @(negedge clk);
    den = 1'b1; dwe = we; daddr = a; di = d;
    @(negedge clk);
    den = 1'b0; dwe = 1'b0;
    chk("drdy_k0", 16'(drdy), 16'h0);
    repeat (2) begin
      @(negedge clk);
      chk("drdy_wait", 16'(drdy), 16'h0);
      chk("do_wait", do_o, 16'h0);
    end
    @(negedge clk);
    chk("drdy_resp", 16'(drdy), 16'h1);
    chk("do_resp", do_o, exp);
    @(negedge clk);
    chk("drdy_after", 16'(drdy), 16'h0);
    chk("do_after", do_o, 16'h0);
  endtask
  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_drdy", 16'(drdy), 16'h0);
    chk("rst_do", do_o, 16'h0);
    chk("rst_ctrl", ctrl_out, 16'h0);
    chk("rst_busy", 16'(busy_err), 16'h0);
    chk("rst_addr", 16'(addr_err), 16'h0);
    txn(1'b0, 10'd0, 16'h0, 16'hD2B0);
    txn(1'b1, 10'd1, 16'hA5A5, 16'h0);
    chk("ctrl_wr", ctrl_out, 16'hA5A5);
    txn(1'b0, 10'd1, 16'h0, 16'hA5A5);
    status_in = 16'h00FF;
    txn(1'b1, 10'd0, 16'h1234, 16'h0);
    txn(1'b1, 10'd2, 16'h1234, 16'h0);
    txn(1'b0, 10'd0, 16'h0, 16'hD2B0);
    txn(1'b0, 10'd2, 16'h0, 16'h00FF);
    chk("addr_err_ro", 16'(addr_err), 16'h0);
    txn(1'b1, 10'd5, 16'hBEEF, 16'h0);
    txn(1'b0, 10'd5, 16'h0, 16'hBEEF);
    txn(1'b0, 10'd20, 16'h0, 16'h0);
    chk("addr_err_rd", 16'(addr_err), 16'h1);
    txn(1'b1, 10'd20, 16'h1111, 16'h0);
    txn(1'b0, 10'd4, 16'h0, 16'h0);
    chk("addr_err_sticky", 16'(addr_err), 16'h1);
    chk("busy_clean", 16'(busy_err), 16'h0);
    // second den one cycle after the first carries a write that must be dropped
    @(negedge clk);
    den = 1'b1; dwe = 1'b0; daddr = 10'd1;
    @(negedge clk);
    dwe = 1'b1; di = 16'hFFFF;
    @(negedge clk);
    den = 1'b0; dwe = 1'b0;
    chk("busy_set", 16'(busy_err), 16'h1);
    chk("busy_drdy0", 16'(drdy), 16'h0);
    chk("busy_ctrl", ctrl_out, 16'hA5A5);
    @(negedge clk);
    chk("busy_drdy1", 16'(drdy), 16'h0);
    @(negedge clk);
    chk("busy_resp", 16'(drdy), 16'h1);
    chk("busy_do", do_o, 16'hA5A5);
    @(negedge clk);
    chk("busy_single", 16'(drdy), 16'h0);
    chk("busy_ctrl_end", ctrl_out, 16'hA5A5);
    txn(1'b0, 10'd1, 16'h0, 16'hA5A5);
    // reset while the write to addr 3 is still in WAIT
    @(negedge clk);
    den = 1'b1; dwe = 1'b1; daddr = 10'd3; di = 16'h5555;
    @(negedge clk);
    den = 1'b0; dwe = 1'b0;
    rst = 1'b1;
    #1;
    chk("mid_rst_ctrl", ctrl_out, 16'h0);
    chk("mid_rst_busy", 16'(busy_err), 16'h0);
    chk("mid_rst_addr", 16'(addr_err), 16'h0);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("mid_rst_nodrdy", 16'(drdy), 16'h0);
    end
    txn(1'b0, 10'd3, 16'h0, 16'h0);
    txn(1'b0, 10'd1, 16'h0, 16'h0);
    chk("end_busy", 16'(busy_err), 16'h0);
    chk("end_addr", 16'(addr_err), 16'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
